proc_core_mc: RTL and testbench
===============================

// Module: proc_core_mc
// PURPOSE
// - Parametrised multi-cycle successor to the single-cycle processor.
// - Accepts one 32-bit instruction per valid/ready handshake and runs it through DECODE, EXEC and WB.
// - Writes results back to an internal register file; flags illegal opcodes.
// - Sits between the instruction source and downstream result consumers.
// PARAMETERS
// - DATA_W  32  datapath and register width, >=16
// - NREGS   8   register count, power of 2, 2..32; RA_W = $clog2(NREGS)
// PORTS
// - clk          in   1       single clock, rising edge
// - reset        in   1       asynchronous, active-high reset
// - instruction  in   32      [31:26] opcode, [25:21] rd, [20:16] rs, [15:0] imm
// - instr_valid  in   1       instruction present
// - instr_ready  out  1       core can accept an instruction
// - result       out  DATA_W  value computed in WB
// - result_valid out  1       1-cycle pulse qualifying result/result_rd
// - result_rd    out  RA_W    destination register index of result
// - illegal      out  1       1-cycle pulse: undefined opcode executed
// - busy         out  1       state != IDLE
// BEHAVIOUR
// - Reset (async): state=IDLE; all regs=0; result=0; result_rd=0; result_valid=0; illegal=0; busy=0; instr_ready=1.
// - FSM: IDLE -(instr_valid&instr_ready)-> DECODE -> EXEC -> WB -> IDLE.
// - MUL adds EXEC2 and EXEC3 between EXEC and WB.
// - instr_ready = (state==IDLE); instruction is latched on the accepting edge.
//   instr_valid while busy is ignored and is not queued.
// - Latency: accept at edge T; result_valid high in cycle T+3, i.e. during WB (T+5 for MUL).
//   instr_ready returns high in the cycle after WB. Throughput is 1 instr per 4 cycles.
// - rd/rs index: low RA_W bits used, upper bits ignored. Operands are read in DECODE.
// - Register 0 reads 0 and writes to it are discarded. result/result_valid are still reported with the computed value.
// - Opcodes:
//   - 0x00 NOP: no write; no result_valid.
//   - 0x01 ADDI: rd = rs + sext(imm).
//   - 0x02 SUBI: rd = rs - sext(imm).
//   - 0x03 ANDI, 0x04 ORI, 0x05 XORI: imm zero-extended.
//   - 0x06 LUI: rd = imm << (DATA_W-16).
//   - 0x07 ADDR: rd = rs + reg[imm[RA_W-1:0]].
// - Arithmetic is modulo 2^DATA_W; no overflow flag; carries are discarded.
// - Any other opcode: illegal pulses in WB; no write; no result_valid; result holds its previous value.
// - Write-then-read: a following instruction reads the value written in the prior WB. No hazard is possible.
// - result and result_rd hold their last values between pulses.
// - Reset mid-operation aborts the instruction: no write, no pulse; the core is ready the cycle after reset deasserts.
// CONFIGURATION
// - `define PROC_MUL_EN: opcode 0x08 MUL, rd = low DATA_W bits of rs * sext(imm), 3 EXEC cycles.
// - Without PROC_MUL_EN: 0x08 is an illegal opcode; EXEC2/EXEC3 and the multiplier are absent.
// TESTING (DATA_W=32, NREGS=8)
// 1. ADDI rd=1 rs=0 imm=5 accepted at T
//    -> result_valid only at T+3, result=5, result_rd=1; instr_ready 0 for T+1..T+3, 1 at T+4.
// 2. After test 1, SUBI rd=2 rs=1 imm=6 -> result=0xFFFFFFFF.
//    Then ADDR rd=3 rs=2 imm=1 -> result=0x00000004.
// 3. ADDI rd=0 rs=0 imm=7 -> result=7, result_rd=0.
//    Then ORI rd=4 rs=0 imm=0 -> result=0 (r0 unchanged).
// 4. Opcode 0x3F -> illegal pulse at T+3, no result_valid; prior register values unchanged (checked via ORI imm=0).
// 5. LUI rd=5 imm=0xABCD, then reset asserted in EXEC of ANDI rd=5
//    -> no result_valid/illegal; after release instr_ready=1; ORI rd=6 rs=5 imm=0 -> 0.
// 6. With PROC_MUL_EN: r1=5, MUL rd=2 rs=1 imm=0xFFFD -> result=0xFFFFFFF1 at T+5.
//    Without the macro: illegal pulse at T+3.

Source files
------------

// File: rtl/proc_core_mc_if.sv
// Instruction handshake and writeback result bus of proc_core_mc.
// Master is the instruction source/result consumer side; slave is the core.
interface proc_core_mc_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 3
);
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [RA_W-1:0]   result_rd;
    logic              illegal;
    logic              busy;

    modport master (
        output instruction, instr_valid,
        input  instr_ready, result, result_valid, result_rd, illegal, busy
    );

    modport slave (
        input  instruction, instr_valid,
        output instr_ready, result, result_valid, result_rd, illegal, busy
    );
endinterface

// File: rtl/proc_core_mc.sv
// Multi-cycle core (DECODE/EXEC/WB, result 3 cycles after accept, 5 for MUL); ready only when idle, valid while busy is dropped.
// `define PROC_MUL_EN enables opcode 0x08 MUL with the extra EXEC2/EXEC3 states.
module proc_core_mc #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic          clk,
    input  logic          reset,
    proc_core_mc_if.slave io
);
    localparam int RA_W = $clog2(NREGS);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUBI = 6'h02;
    localparam logic [5:0] OP_ANDI = 6'h03;
    localparam logic [5:0] OP_ORI  = 6'h04;
    localparam logic [5:0] OP_XORI = 6'h05;
    localparam logic [5:0] OP_LUI  = 6'h06;
    localparam logic [5:0] OP_ADDR = 6'h07;
`ifdef PROC_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'h08;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
`ifdef PROC_MUL_EN
        S_EXEC2,
        S_EXEC3,
`endif
        S_WB
    } state_t;

    state_t                        state_q, state_d;
    logic [31:0]                   instr_q, instr_d;
    logic [DATA_W-1:0]             op_a_q, op_a_d;
    logic [DATA_W-1:0]             op_b_q, op_b_d;
    logic [NREGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]             result_q, result_d;
    logic [RA_W-1:0]               result_rd_q, result_rd_d;
    logic                          result_valid_q, result_valid_d;
    logic                          illegal_q, illegal_d;
    logic                          ready_q, ready_d;
    logic                          busy_q, busy_d;
`ifdef PROC_MUL_EN
    logic [DATA_W-1:0]             mul_q, mul_d;
`endif

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rd, rs;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext, imm_zext, alu_res;
    logic              op_legal, enter_wb;
    logic              unused_instr;

    // Only the low RA_W bits of the register fields select a register.
    assign opcode       = instr_q[31:26];
    assign rd           = instr_q[21 +: RA_W];
    assign rs           = instr_q[16 +: RA_W];
    assign imm          = instr_q[15:0];
    assign imm_sext     = DATA_W'($signed(imm));
    assign imm_zext     = DATA_W'(imm);
    assign unused_instr = ^instr_q;

`ifdef PROC_MUL_EN
    assign op_legal = (opcode <= OP_ADDR) || (opcode == OP_MUL);
`else
    assign op_legal = (opcode <= OP_ADDR);
`endif

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADDI: alu_res = op_a_q + imm_sext;
            OP_SUBI: alu_res = op_a_q - imm_sext;
            OP_ANDI: alu_res = op_a_q & imm_zext;
            OP_ORI:  alu_res = op_a_q | imm_zext;
            OP_XORI: alu_res = op_a_q ^ imm_zext;
            OP_LUI:  alu_res = imm_zext << (DATA_W - 16);
            OP_ADDR: alu_res = op_a_q + op_b_q;
`ifdef PROC_MUL_EN
            OP_MUL:  alu_res = mul_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        regs_d         = regs_q;
        result_d       = result_q;
        result_rd_d    = result_rd_q;
        result_valid_d = 1'b0;
        illegal_d      = 1'b0;
        enter_wb       = 1'b0;
`ifdef PROC_MUL_EN
        mul_d          = mul_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io.instr_valid && ready_q) begin
                    instr_d = io.instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_d  = regs_q[rs];
                op_b_d  = regs_q[imm[RA_W-1:0]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
`ifdef PROC_MUL_EN
                if (opcode == OP_MUL) begin
                    mul_d   = op_a_q * imm_sext;
                    state_d = S_EXEC2;
                end else begin
                    enter_wb = 1'b1;
                    state_d  = S_WB;
                end
`else
                enter_wb = 1'b1;
                state_d  = S_WB;
`endif
            end
`ifdef PROC_MUL_EN
            S_EXEC2: state_d = S_EXEC3;
            S_EXEC3: begin
                enter_wb = 1'b1;
                state_d  = S_WB;
            end
`endif
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Commit on entry to WB so the registered pulses line up with the WB cycle.
        if (enter_wb) begin
            if (!op_legal) begin
                illegal_d = 1'b1;
            end else if (opcode != OP_NOP) begin
                result_d       = alu_res;
                result_rd_d    = rd;
                result_valid_d = 1'b1;
                if (rd != '0) begin
                    regs_d[rd] = alu_res;
                end
            end
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            regs_q         <= '0;
            result_q       <= '0;
            result_rd_q    <= '0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
`ifdef PROC_MUL_EN
            mul_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            regs_q         <= regs_d;
            result_q       <= result_d;
            result_rd_q    <= result_rd_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
`ifdef PROC_MUL_EN
            mul_q          <= mul_d;
`endif
        end
    end

    assign io.instr_ready  = ready_q;
    assign io.busy         = busy_q;
    assign io.result       = result_q;
    assign io.result_rd    = result_rd_q;
    assign io.result_valid = result_valid_q;
    assign io.illegal      = illegal_q;
endmodule

// File: tb/tb_proc_core_mc.sv
// Self-checking bench for proc_core_mc (DATA_W=32, NREGS=8): directed table, reset abort, modelled random run.
module tb_proc_core_mc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    proc_core_mc_if #(.DATA_W(32), .RA_W(3)) io();
    proc_core_mc #(.DATA_W(32), .NREGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    typedef struct {
        logic [31:0] instr;
        int          lat;
        logic        vld;
        logic        ill;
        logic [31:0] res;
        logic [2:0]  rd;
    } vec_t;

    vec_t        tbl[$];
    vec_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mregs [8];
    logic [31:0] last_res;
    logic [2:0]  last_rd;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input int lat, input logic vld,
                                input logic ill, input logic [31:0] res, input logic [2:0] rd);
        vec_t v;
        v.instr = instr; v.lat = lat; v.vld = vld; v.ill = ill; v.res = res; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Drive one instruction; garbage stays valid while busy to show it is not taken.
    task automatic send(input vec_t v);
        vec_t e;
        int   waited = 0;
        while (io.instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_send", 32'(io.instr_ready), 32'd1);
        io.instruction = v.instr;
        io.instr_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(v);
        @(negedge clk);
        io.instruction = enc(6'h01, 5'd7, 5'd0, 16'h5A5A);
        for (int c = 1; c <= v.lat + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c == v.lat) begin
                io.instr_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_valid", 32'(io.result_valid), 32'(e.vld));
                    chk("illegal", 32'(io.illegal), 32'(e.ill));
                    chk("result", io.result, e.res);
                    chk("result_rd", 32'(io.result_rd), 32'(e.rd));
                end
            end else begin
                chk("no_pulse", 32'({io.result_valid, io.illegal}), 32'd0);
            end
            chk("instr_ready", 32'(io.instr_ready), 32'(c > v.lat));
            chk("busy", 32'(io.busy), 32'(c <= v.lat));
        end
    endtask

    task automatic predict(input logic [31:0] ins, output vec_t v);
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] a, b, r;
        op  = ins[31:26];
        imm = ins[15:0];
        a   = mregs[ins[18:16]];
        b   = mregs[ins[2:0]];
        r   = 32'd0;
        case (op)
            6'h01: r = a + {{16{imm[15]}}, imm};
            6'h02: r = a - {{16{imm[15]}}, imm};
            6'h03: r = a & {16'h0, imm};
            6'h04: r = a | {16'h0, imm};
            6'h05: r = a ^ {16'h0, imm};
            6'h06: r = {imm, 16'h0};
            6'h07: r = a + b;
            default: r = 32'd0;
        endcase
        v.instr = ins;
        v.lat   = 3;
        v.vld   = (op >= 6'h01 && op <= 6'h07);
        v.ill   = (op > 6'h07);
        if (v.vld) begin
            last_res = r;
            last_rd  = ins[23:21];
            if (ins[23:21] != 3'd0) mregs[ins[23:21]] = r;
        end
        v.res = last_res;
        v.rd  = last_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl.push_back(mk(enc(6'h01, 5'd1, 5'd0, 16'd5),      3, 1'b1, 1'b0, 32'h0000_0005, 3'd1));
        tbl.push_back(mk(enc(6'h02, 5'd2, 5'd1, 16'd6),      3, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd2));
        tbl.push_back(mk(enc(6'h07, 5'd3, 5'd2, 16'd1),      3, 1'b1, 1'b0, 32'h0000_0004, 3'd3));
        tbl.push_back(mk(enc(6'h01, 5'd0, 5'd0, 16'd7),      3, 1'b1, 1'b0, 32'h0000_0007, 3'd0));
        tbl.push_back(mk(enc(6'h04, 5'd4, 5'd0, 16'd0),      3, 1'b1, 1'b0, 32'h0000_0000, 3'd4));
        tbl.push_back(mk(enc(6'h3F, 5'd3, 5'd1, 16'd9),      3, 1'b0, 1'b1, 32'h0000_0000, 3'd4));
        tbl.push_back(mk(enc(6'h04, 5'd4, 5'd3, 16'd0),      3, 1'b1, 1'b0, 32'h0000_0004, 3'd4));
        tbl.push_back(mk(enc(6'h00, 5'd5, 5'd1, 16'd3),      3, 1'b0, 1'b0, 32'h0000_0004, 3'd4));
        tbl.push_back(mk(enc(6'h03, 5'd7, 5'd2, 16'hF0F0),   3, 1'b1, 1'b0, 32'h0000_F0F0, 3'd7));
        tbl.push_back(mk(enc(6'h05, 5'd6, 5'd2, 16'h8001),   3, 1'b1, 1'b0, 32'hFFFF_7FFE, 3'd6));
        tbl.push_back(mk(enc(6'h01, 5'd5, 5'd1, 16'hFFFF),   3, 1'b1, 1'b0, 32'h0000_0004, 3'd5));
        tbl.push_back(mk(enc(6'h06, 5'd1, 5'd0, 16'h1234),   3, 1'b1, 1'b0, 32'h1234_0000, 3'd1));
        tbl.push_back(mk(enc(6'h01, 5'd9, 5'd9, 16'd1),      3, 1'b1, 1'b0, 32'h1234_0001, 3'd1));
        tbl.push_back(mk(enc(6'h01, 5'd1, 5'd0, 16'd5),      3, 1'b1, 1'b0, 32'h0000_0005, 3'd1));
`ifdef PROC_MUL_EN
        tbl.push_back(mk(enc(6'h08, 5'd2, 5'd1, 16'hFFFD),   5, 1'b1, 1'b0, 32'hFFFF_FFF1, 3'd2));
        tbl.push_back(mk(enc(6'h04, 5'd7, 5'd2, 16'd0),      3, 1'b1, 1'b0, 32'hFFFF_FFF1, 3'd7));
`else
        tbl.push_back(mk(enc(6'h08, 5'd2, 5'd1, 16'hFFFD),   3, 1'b0, 1'b1, 32'h0000_0005, 3'd1));
        tbl.push_back(mk(enc(6'h04, 5'd7, 5'd2, 16'd0),      3, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd7));
`endif

        reset          = 1'b1;
        io.instr_valid = 1'b0;
        io.instruction = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(io.instr_ready), 32'd1);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_pulses", 32'({io.result_valid, io.illegal}), 32'd0);
        chk("rst_result", io.result, 32'd0);
        chk("rst_result_rd", 32'(io.result_rd), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i]);
        end

        // Reset while an ANDI sits in EXEC: the instruction is lost and registers clear.
        send(mk(enc(6'h06, 5'd5, 5'd0, 16'hABCD), 3, 1'b1, 1'b0, 32'hABCD_0000, 3'd5));
        io.instruction = enc(6'h03, 5'd5, 5'd5, 16'hFFFF);
        io.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(io.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(io.instr_ready), 32'd1);
        chk("abort_busy", 32'(io.busy), 32'd0);
        chk("abort_result", io.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_pulse", 32'({io.result_valid, io.illegal}), 32'd0);
            chk("abort_idle_ready", 32'(io.instr_ready), 32'd1);
        end
        send(mk(enc(6'h04, 5'd6, 5'd5, 16'd0), 3, 1'b1, 1'b0, 32'h0000_0000, 3'd6));

        for (int r = 0; r < 8; r++) mregs[r] = 32'd0;
        last_res = 32'd0;
        last_rd  = 3'd6;
        for (int i = 0; i < 40; i++) begin
            int          pick;
            logic [5:0]  op;
            pick = $urandom_range(0, 9);
            op   = (pick <= 7) ? 6'(pick) : ((pick == 8) ? 6'h3F : 6'h2A);
            predict(enc(op, 5'($urandom), 5'($urandom), 16'($urandom)), v);
            send(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
